// File: rtl/frame_reader_vga_pkg.sv
// Shared constants and types for the VGA frame reader: 640x480@60 timing,
// RGB332 pixel width, genram address width and the sideband control bundle.
package frame_reader_vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int RGB_W  = 8;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 10;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Sync/enable bits travelling alongside the RAM read, one stage per clock.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic img;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, img: 1'b0};

endpackage

// File: rtl/frame_reader_vga_if.sv
// genram read port as seen by the frame reader (master) and the RAM (slave).
interface frame_reader_vga_if;
  import frame_reader_vga_pkg::*;

  addr_t rd_addr;
  logic  rd_en;
  rgb_t  data_in;

  modport master (output rd_addr, output rd_en, input data_in);
  modport slave  (input rd_addr, input rd_en, output data_in);

endinterface

// File: rtl/frame_reader_vga_timing.sv
// Raster counters for the VGA scan: raw sync/enable, line/frame wrap strobes
// and a frame_start pulse aligned with the counter state 0,0.
module vga_timing
  import frame_reader_vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic line_end,
  output logic frame_wrap,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic frame_start_q, frame_start_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hcnt_d     = hcnt_q + cnt_t'(1);
    vcnt_d     = vcnt_q;
    line_end   = (hcnt_q == cnt_t'(H_TOTAL - 1));
    frame_wrap = line_end && (vcnt_q == cnt_t'(V_TOTAL - 1));
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = frame_wrap ? '0 : vcnt_q + cnt_t'(1);
    end
    // Registered from the next state so the pulse coincides with 0,0.
    frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so it is just the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign frame_start = frame_start_q;
  assign de          = (hcnt_q < cnt_t'(H_ACTIVE)) && (vcnt_q < cnt_t'(V_ACTIVE));
  assign hsync       = !((hcnt_q >= cnt_t'(H_ACTIVE + H_FP)) &&
                         (hcnt_q <  cnt_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync       = !((vcnt_q >= cnt_t'(V_ACTIVE + V_FP)) &&
                         (vcnt_q <  cnt_t'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/frame_reader_vga.sv
// Scans the camera frame buffer in raster order and drives VGA with each stored
// pixel upscaled to a 2^SCALE square; two-clock pipeline counter -> RAM -> pins.
module frame_reader_vga
  import frame_reader_vga_pkg::*;
#(
  parameter int   IMG_W    = 160,
  parameter int   IMG_H    = 120,
  parameter int   SCALE    = 2,
  parameter rgb_t BORDER   = 8'h00,
  parameter rgb_t BLANK    = 8'h00,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_done,
  frame_reader_vga_if.master        ram,
  output logic                      vga_hsync,
  output logic                      vga_vsync,
  output logic                      vga_de,
  output rgb_t                      vga_rgb,
  output logic                      frame_start
);

  localparam cnt_t IMG_XE   = cnt_t'(IMG_W << SCALE);
  localparam cnt_t IMG_YE   = cnt_t'(IMG_H << SCALE);
  localparam cnt_t SUB_MASK = cnt_t'((1 << SCALE) - 1);

  cnt_t hcnt, vcnt;
  logic hs_raw, vs_raw, de_raw, line_end, frame_wrap;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .hsync      (hs_raw),
    .vsync      (vs_raw),
    .de         (de_raw),
    .line_end   (line_end),
    .frame_wrap (frame_wrap),
    .frame_start(frame_start)
  );

  addr_t    line_base_q, line_base_d;
  addr_t    rd_addr_q, rd_addr_d;
  logic     rd_en_q, rd_en_d;
  logic     have_frame_q, have_frame_d;
  logic     show_frame_q, show_frame_d;
  vga_ctl_t ctl_q, ctl_d;
  logic     hsync_q, vsync_q, de_q;
  rgb_t     rgb_q, rgb_d;
  logic     in_img, row_in_img, at_origin;

  always_comb begin
    row_in_img = vcnt < IMG_YE;
    in_img     = de_raw && (hcnt < IMG_XE) && row_in_img;
    at_origin  = (hcnt == '0) && (vcnt == '0);

    // Row base advances once per 2^SCALE screen lines instead of multiplying.
    line_base_d = line_base_q;
    if (frame_wrap)
      line_base_d = '0;
    else if (line_end && row_in_img && ((vcnt & SUB_MASK) == SUB_MASK))
      line_base_d = line_base_q + addr_t'(IMG_W);

    rd_en_d   = in_img;
    rd_addr_d = in_img ? line_base_q + addr_t'(hcnt >> SCALE) : rd_addr_q;
    ctl_d     = '{hsync: hs_raw, vsync: vs_raw, de: de_raw, img: in_img};

    // The shown frame only changes at the top-left corner, so no tearing.
    have_frame_d = have_frame_q | frame_done;
    show_frame_d = at_origin ? (have_frame_q | frame_done) : show_frame_q;

    rgb_d = BORDER;
    if (!ctl_q.de)
      rgb_d = '0;
    else if (ctl_q.img)
      rgb_d = show_frame_q ? ram.data_in : BLANK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_base_q  <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      have_frame_q <= 1'b0;
      show_frame_q <= 1'b0;
      ctl_q        <= CTL_IDLE;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      rgb_q        <= '0;
    end else begin
      line_base_q  <= line_base_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      have_frame_q <= have_frame_d;
      show_frame_q <= show_frame_d;
      ctl_q        <= ctl_d;
      hsync_q      <= ctl_q.hsync;
      vsync_q      <= ctl_q.vsync;
      de_q         <= ctl_q.de;
      rgb_q        <= rgb_d;
    end
  end

  assign ram.rd_addr = rd_addr_q;
  assign ram.rd_en   = rd_en_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_frame_reader_vga.sv
// Directed bench: full-size reader (a) for reset/hsync/addressing/mid-line reset,
// short-frame reader (b) with a narrow image for border, vsync and frame latching.
module tb_frame_reader_vga;
  import frame_reader_vga_pkg::*;

  logic clk;
  logic rst_a, fd_a, rst_b, fd_b;
  logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  rgb_t rgb_a, rgb_b;

  int n_cmp = 0;
  int n_err = 0;
  int pos_a = 0;

  frame_reader_vga_if bus_a ();
  frame_reader_vga_if bus_b ();

  // RAM model: byte at address = low address bits; poison value when not enabled.
  assign bus_a.data_in = bus_a.rd_en ? bus_a.rd_addr[7:0] : 8'hEE;
  assign bus_b.data_in = bus_b.rd_en ? bus_b.rd_addr[7:0] : 8'hEE;

  frame_reader_vga dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .frame_done (fd_a),
    .ram        (bus_a.master),
    .vga_hsync  (hs_a),
    .vga_vsync  (vs_a),
    .vga_de     (de_a),
    .vga_rgb    (rgb_a),
    .frame_start(fs_a)
  );

  // 800 x 30 raster, 100 x 6 image upscaled to 400 x 24.
  frame_reader_vga #(
    .IMG_W(100), .IMG_H(6), .SCALE(2), .BORDER(8'h03), .BLANK(8'h55),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .frame_done (fd_b),
    .ram        (bus_b.master),
    .vga_hsync  (hs_b),
    .vga_vsync  (vs_b),
    .vga_de     (de_b),
    .vga_rgb    (rgb_b),
    .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // pos_a = rising edges since reset release; outputs at pos p show counter state p-2.
  task advance_a(input int target);
    while (pos_a < target) begin
      @(negedge clk);
      pos_a++;
    end
  endtask

  initial begin
    rst_a = 1'b0; fd_a = 1'b0;
    rst_b = 1'b0; fd_b = 1'b0;
    repeat (3) @(negedge clk);

    fork
      begin : run_a
        int hs_low, de_high;
        check("a_rst_hsync",  32'(hs_a), 32'd1);
        check("a_rst_vsync",  32'(vs_a), 32'd1);
        check("a_rst_de",     32'(de_a), 32'd0);
        check("a_rst_rgb",    32'(rgb_a), 32'h00);
        check("a_rst_rd_en",  32'(bus_a.rd_en), 32'd0);
        check("a_rst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
        check("a_rst_fstart", 32'(fs_a), 32'd0);

        // frame_done coincident with the 0,0 boundary right after release.
        rst_a = 1'b1; fd_a = 1'b1; pos_a = 0;
        advance_a(1); fd_a = 1'b0;

        advance_a(657); check("a_hsync_pre",  32'(hs_a), 32'd1);
        advance_a(658); check("a_hsync_fall", 32'(hs_a), 32'd0);
        advance_a(753); check("a_hsync_last", 32'(hs_a), 32'd0);
        advance_a(754); check("a_hsync_rise", 32'(hs_a), 32'd1);

        hs_low = 0; de_high = 0;
        for (int i = 0; i < 800; i++) begin
          advance_a(pos_a + 1);
          if (!hs_a) hs_low++;
          if (de_a)  de_high++;
        end
        check("a_line_hsync_low", 32'(hs_low), 32'd96);
        check("a_line_de_high",   32'(de_high), 32'd640);

        advance_a(4010); check("a_addr_y5_x9", 32'(bus_a.rd_addr), 32'd162);
                         check("a_rden_y5_x9", 32'(bus_a.rd_en), 32'd1);
        advance_a(4011); check("a_rgb_y5_x9",  32'(rgb_a), 32'hA2);
        advance_a(4014); check("a_addr_y5_x13", 32'(bus_a.rd_addr), 32'd163);
        advance_a(4640); check("a_addr_y5_x639", 32'(bus_a.rd_addr), 32'd319);
        advance_a(4641); check("a_rden_x640", 32'(bus_a.rd_en), 32'd0);
                         check("a_addr_hold", 32'(bus_a.rd_addr), 32'd319);
        advance_a(4642); check("a_de_x640",   32'(de_a), 32'd0);
                         check("a_rgb_x640",  32'(rgb_a), 32'h00);

        advance_a(40300); check("a_rgb_y50_x298", 32'(rgb_a), 32'hCA);
        rst_a = 1'b0;
        @(negedge clk);
        check("a_mid_rst_hsync", 32'(hs_a), 32'd1);
        check("a_mid_rst_de",    32'(de_a), 32'd0);
        check("a_mid_rst_rgb",   32'(rgb_a), 32'h00);
        check("a_mid_rst_rd_en", 32'(bus_a.rd_en), 32'd0);
        check("a_mid_rst_addr",  32'(bus_a.rd_addr), 32'd0);

        rst_a = 1'b1; pos_a = 0;
        advance_a(4010); check("a_restart_addr", 32'(bus_a.rd_addr), 32'd162);
        advance_a(4011); check("a_restart_de",   32'(de_a), 32'd1);
                         check("a_restart_blank", 32'(rgb_a), 32'h00);
      end

      begin : run_b
        int vs_low, de_high, fs_cnt;
        vs_low = 0; de_high = 0; fs_cnt = 0;
        rst_b = 1'b1;
        for (int p = 1; p <= 52011; p++) begin
          @(negedge clk);
          if (p >= 2 && p <= 24001) begin
            if (!vs_b) vs_low++;
            if (de_b)  de_high++;
          end
          if (p <= 48000 && fs_b) fs_cnt++;
          case (p)
            4010:  begin
                     check("b_addr_y5_x9", 32'(bus_b.rd_addr), 32'd102);
                     check("b_rden_y5_x9", 32'(bus_b.rd_en), 32'd1);
                   end
            4011:  check("b_blank_f1", 32'(rgb_b), 32'h55);
            4401:  begin
                     check("b_rden_x400", 32'(bus_b.rd_en), 32'd0);
                     check("b_addr_hold_x400", 32'(bus_b.rd_addr), 32'd199);
                   end
            4402:  begin
                     check("b_de_x400",  32'(de_b), 32'd1);
                     check("b_border_x400", 32'(rgb_b), 32'h03);
                   end
            4641:  check("b_border_x639", 32'(rgb_b), 32'h03);
            4642:  check("b_rgb_x640", 32'(rgb_b), 32'h00);
            18800: check("b_addr_last", 32'(bus_b.rd_addr), 32'd599);
            20801: check("b_vsync_pre",  32'(vs_b), 32'd1);
            20802: check("b_vsync_fall", 32'(vs_b), 32'd0);
            23999: check("b_fstart_pre",  32'(fs_b), 32'd0);
            24000: check("b_fstart_f2",   32'(fs_b), 32'd1);
            24001: check("b_fstart_post", 32'(fs_b), 32'd0);
            24002: begin
                     check("b_frame_vsync_low", 32'(vs_low), 32'd1600);
                     check("b_frame_de_high",   32'(de_high), 32'd15360);
                   end
            32000: fd_b = 1'b1;
            32001: fd_b = 1'b0;
            36011: check("b_blank_f2_after_done", 32'(rgb_b), 32'h55);
            48001: check("b_fstart_count", 32'(fs_cnt), 32'd2);
            52011: check("b_data_f3", 32'(rgb_b), 32'h66);
            default: ;
          endcase
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
